// File: rtl/cpu_pkg.sv
// Shared constants for the register-file / bus / MDR datapath.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int SEL_W      = 5;

  localparam logic [31:0] MEM_DATA = 32'hDEADBEEF;

  localparam logic [SEL_W-1:0] SEL_REG_MIN = 5'd0;
  localparam logic [SEL_W-1:0] SEL_REG_MAX = 5'd15;
  localparam logic [SEL_W-1:0] SEL_MDR     = 5'd21;

  // Register codes occupy the whole lower half of the select space.
  function automatic logic sel_is_reg(input logic [SEL_W-1:0] sel);
    return (sel >= SEL_REG_MIN) && (sel <= SEL_REG_MAX);
  endfunction

endpackage

// File: rtl/mdr_reg.sv
// Memory data register: loads either the bus or the constant memory word.
module mdr_reg #(
  parameter int                DATA_W   = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0] MEM_DATA = DATA_W'(cpu_pkg::MEM_DATA)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              read,
  input  logic [DATA_W-1:0] bus_i,
  output logic [DATA_W-1:0] mdr_o
);

  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] mdr_d;

  // bus_i may be mdr_o itself; the register breaks that path, so no loop.
  always_comb begin
    mdr_d = mdr_q;
    if (load) begin
      mdr_d = read ? MEM_DATA : bus_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdr_q <= '0;
    end else begin
      mdr_q <= mdr_d;
    end
  end

  assign mdr_o = mdr_q;

endmodule

// File: rtl/cpu_top.sv
// Datapath slice: 16-entry register file, source-select bus mux and the MDR.
module cpu_top #(
  parameter int                DATA_W   = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0] MEM_DATA = DATA_W'(cpu_pkg::MEM_DATA)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [3:0]        addr_in,
  input  logic [3:0]        addr_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [4:0]        reg_out_select,
  input  logic              read,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] mdr_out
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] reg_rd;
  logic [DATA_W-1:0] mdr_val;
  logic [DATA_W-1:0] bus_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (load) begin
      regs_q[addr_in] <= data_in;
    end
  end

  assign reg_rd = regs_q[addr_out];

  always_comb begin
    bus_val = '0;
    if (sel_is_reg(reg_out_select)) begin
      bus_val = reg_rd;
    end else if (reg_out_select == SEL_MDR) begin
      bus_val = mdr_val;
    end
  end

  // The MDR samples the pre-edge bus, so a same-edge register write is not seen.
  mdr_reg #(
    .DATA_W  (DATA_W),
    .MEM_DATA(MEM_DATA)
  ) u_mdr (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .read (read),
    .bus_i(bus_val),
    .mdr_o(mdr_val)
  );

  assign bus_out = bus_val;
  assign mdr_out = mdr_val;

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: directed vector table, corner sequences, random vs model.
module tb_cpu_top;

  localparam int W = 32;
  localparam logic [W-1:0] MEM = 32'hDEADBEEF;

  logic         clk;
  logic         reset;
  logic         load;
  logic [3:0]   addr_in;
  logic [3:0]   addr_out;
  logic [W-1:0] data_in;
  logic [4:0]   reg_out_select;
  logic         read;
  logic [W-1:0] bus_out;
  logic [W-1:0] mdr_out;

  int n_vec;
  int n_err;

  cpu_top dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .addr_in       (addr_in),
    .addr_out      (addr_out),
    .data_in       (data_in),
    .reg_out_select(reg_out_select),
    .read          (read),
    .bus_out       (bus_out),
    .mdr_out       (mdr_out)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ld;
    logic         rd;
    logic [3:0]   ain;
    logic [3:0]   aout;
    logic [W-1:0] din;
    logic [4:0]   sel;
    logic [W-1:0] exp_bus;
    logic [W-1:0] exp_mdr;
  } vec_t;

  vec_t vecs[$];

  // reference model: architectural state only
  logic [W-1:0] m_regs [16];
  logic [W-1:0] m_mdr;

  function automatic logic [W-1:0] model_bus(input logic [4:0] sel, input logic [3:0] ao);
    if (sel < 5'd16) return m_regs[ao];
    if (sel == 5'd21) return m_mdr;
    return '0;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic rd, input logic [3:0] ain,
                       input logic [3:0] aout, input logic [W-1:0] din, input logic [4:0] sel);
    reset = rst; load = ld; read = rd; addr_in = ain;
    addr_out = aout; data_in = din; reg_out_select = sel;
  endtask

  task automatic add(input logic rst, input logic ld, input logic rd, input logic [3:0] ain,
                     input logic [3:0] aout, input logic [W-1:0] din, input logic [4:0] sel,
                     input logic [W-1:0] eb, input logic [W-1:0] em);
    vec_t v;
    v.rst = rst; v.ld = ld; v.rd = rd; v.ain = ain; v.aout = aout;
    v.din = din; v.sel = sel; v.exp_bus = eb; v.exp_mdr = em;
    vecs.push_back(v);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, '0, 5'd0);

    // Each vector: drive inputs, take one edge, then compare with inputs still held.
    //   rst ld rd ain aout din           sel    bus           mdr
    add(1, 0, 0, 0, 0, 32'h0,        5'd0,  32'h0,        32'h0);        // reset
    add(0, 1, 0, 0, 0, 32'hABCD1234, 5'd0,  32'hABCD1234, 32'h0);        // write R0, MDR sees old bus
    add(0, 1, 0, 1, 0, 32'h0,        5'd0,  32'hABCD1234, 32'hABCD1234); // reg -> MDR
    add(0, 1, 1, 2, 0, 32'h0,        5'd0,  32'hABCD1234, MEM);          // memory load
    add(0, 0, 0, 2, 0, 32'h0,        5'd0,  32'hABCD1234, MEM);          // hold
    add(0, 0, 0, 2, 0, 32'h0,        5'd0,  32'hABCD1234, MEM);          // hold
    add(0, 0, 0, 2, 0, 32'h0,        5'd21, MEM,          MEM);          // MDR on bus
    add(0, 1, 0, 3, 0, 32'h0,        5'd21, MEM,          MEM);          // self reload
    add(1, 1, 1, 0, 0, 32'hFFFFFFFF, 5'd0,  32'h0,        32'h0);        // reset beats load
    add(0, 1, 0, 5, 5, 32'h12345678, 5'd16, 32'h0,        32'h0);
    add(0, 1, 0, 9, 9, 32'hCAFEF00D, 5'd31, 32'h0,        32'h0);
    add(0, 0, 0, 0, 5, 32'h0,        5'd3,  32'h12345678, 32'h0);        // low bits ignored
    add(0, 0, 0, 0, 9, 32'h0,        5'd3,  32'hCAFEF00D, 32'h0);
    add(0, 0, 0, 0, 5, 32'h0,        5'd15, 32'h12345678, 32'h0);
    add(0, 0, 0, 0, 0, 32'h0,        5'd0,  32'h0,        32'h0);        // R0 was cleared by reset
    add(0, 1, 0, 9, 9, 32'h11111111, 5'd15, 32'h11111111, 32'hCAFEF00D); // simultaneous write+load
    add(0, 0, 0, 0, 9, 32'h0,        5'd20, 32'h0,        32'hCAFEF00D);
    add(0, 0, 0, 0, 9, 32'h0,        5'd22, 32'h0,        32'hCAFEF00D);
    add(0, 0, 0, 0, 9, 32'h0,        5'd21, 32'hCAFEF00D, 32'hCAFEF00D);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].rd, vecs[i].ain, vecs[i].aout, vecs[i].din, vecs[i].sel);
      @(posedge clk); #1;
      check($sformatf("vec%0d.bus", i), bus_out, vecs[i].exp_bus);
      check($sformatf("vec%0d.mdr", i), mdr_out, vecs[i].exp_mdr);
    end

    // Zero-latency bus: switching select between edges updates bus immediately.
    drive(0, 0, 0, 0, 9, '0, 5'd3);
    #1 check("comb.reg9", bus_out, 32'h11111111);
    reg_out_select = 5'd21;
    #1 check("comb.mdr", bus_out, 32'hCAFEF00D);
    reg_out_select = 5'd18;
    #1 check("comb.zero", bus_out, 32'h0);

    // Reset pulse between edges has no effect.
    reg_out_select = 5'd3;
    @(negedge clk);
    reset = 1'b1;
    #2 check("midreset.mdr", mdr_out, 32'hCAFEF00D);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midreset.mdr_after", mdr_out, 32'hCAFEF00D);
    check("midreset.reg9", bus_out, 32'h11111111);

    // Random phase against the model.
    drive(1, 0, 0, 0, 0, '0, 5'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_mdr = '0;
    check("rand.reset_mdr", mdr_out, 32'h0);
    for (int n = 0; n < 400; n++) begin
      logic [4:0] s;
      logic [W-1:0] pre_bus;
      case ($urandom_range(0, 3))
        0: s = 5'd21;
        1: s = 5'($urandom_range(16, 31));
        default: s = 5'($urandom_range(0, 15));
      endcase
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, s);
      @(negedge clk);
      pre_bus = model_bus(reg_out_select, addr_out);
      check("rand.bus", bus_out, pre_bus);
      check("rand.mdr", mdr_out, m_mdr);
      if (reset) begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_mdr = '0;
      end else if (load) begin
        m_mdr = read ? MEM : pre_bus;
        m_regs[addr_in] = data_in;
      end
      @(posedge clk); #1;
    end
    check("rand.final_mdr", mdr_out, m_mdr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
